// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, SubBytes engine states and the
// legal-lane-count check used at elaboration.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } subbytes_state_t;

    // Lane counts must divide the 16-byte state evenly into a power-of-two group.
    function automatic bit lanes_legal(input int unsigned lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box: one byte in, one substituted byte out.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX_LUT [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_LUT[in_byte];

endmodule

// File: rtl/subbytes_serial.sv
// Byte-serial AES SubBytes engine. A 128-bit state is accepted on a
// valid/ready handshake, streamed LANES bytes per cycle through LANES sbox
// instances and reassembled into a 128-bit result held until consumed.
module subbytes_serial
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 1,
    parameter int unsigned PIPE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int unsigned N     = AES_BYTES / LANES;
    localparam int unsigned CNT_W = $clog2(N) + 1;
    localparam int unsigned GRP_W = 8 * LANES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (!lanes_legal(LANES)) begin : g_bad_lanes
            $error("subbytes_serial: LANES must be 1, 2, 4, 8 or 16");
        end
        if (PIPE > 1) begin : g_bad_pipe
            $error("subbytes_serial: PIPE must be 0 or 1");
        end
    endgenerate

    subbytes_state_t        state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_BLOCK_W-1:0] src_q;
    logic [AES_BLOCK_W-1:0] res_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic                   accept;
    logic                   run_en;
    logic [GRP_W-1:0]       sub_grp;
    logic [GRP_W-1:0]       res_grp;
    logic                   res_shift;
    logic [AES_BLOCK_W-1:0] grp_top;

    assign accept = (state_q == IDLE) && in_valid;
    assign run_en = (state_q == RUN);

    // One sbox per lane, fed from the low bytes of the source register.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox u_sbox (
            .in_byte  (src_q[8*i +: 8]),
            .out_byte (sub_grp[8*i +: 8])
        );
    end

    // Control FSM with registered handshake and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        if (PIPE != 0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Source register: loaded on accept, consumed LANES bytes per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else if (accept) begin
            src_q <= in_data;
        end else if (run_en) begin
            src_q <= src_q >> GRP_W;
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic [GRP_W-1:0] pipe_q;
            logic             shift_d_q;

            // Pipeline register after the sbox; the result shift trails RUN by one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q    <= '0;
                    shift_d_q <= 1'b0;
                end else begin
                    shift_d_q <= run_en;
                    if (run_en) begin
                        pipe_q <= sub_grp;
                    end
                end
            end

            assign res_grp   = pipe_q;
            assign res_shift = shift_d_q;
        end else begin : g_comb
            assign res_grp   = sub_grp;
            assign res_shift = run_en;
        end
    endgenerate

    // Substituted group enters at the top; a shift (not a slice) keeps LANES=16 legal.
    assign grp_top = AES_BLOCK_W'(res_grp) << (AES_BLOCK_W - GRP_W);

    // Result register: after N shifts byte i sits in position i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (res_shift) begin
            res_q <= (res_q >> GRP_W) | grp_top;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = res_q;

endmodule

// File: tb/tb_subbytes_serial.sv
// Self-checking bench for subbytes_serial: all LANES/PIPE configurations,
// directed vectors, backpressure, mid-run reset and random traffic against
// a GF(2^8) inverse + affine S-box reference.
module tb_subbytes_serial;

    localparam int NCFG = 10;

    logic         clk;
    logic         rst_n;
    logic         in_valid_a  [NCFG];
    logic [127:0] in_data_a   [NCFG];
    logic         out_ready_a [NCFG];
    logic         in_ready_a  [NCFG];
    logic         out_valid_a [NCFG];
    logic         busy_a      [NCFG];
    logic [127:0] out_data_a  [NCFG];

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Config g: LANES = 1 << (g/2), PIPE = g % 2.
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        subbytes_serial #(
            .LANES (1 << (g / 2)),
            .PIPE  (g % 2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .busy      (busy_a[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] subbytes_ref(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic build_ref();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    // One transfer with out_ready held high; lat counts edges after the accepting edge.
    task automatic xfer(input int k, input logic [127:0] d, output int lat,
                        output logic [127:0] res, output int low, output logic valid_after);
        @(negedge clk);
        in_valid_a[k]  = 1'b1;
        in_data_a[k]   = d;
        out_ready_a[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
        in_data_a[k]  = rand128();
        lat = -1;
        low = 0;
        res = '0;
        valid_after = 1'bx;
        for (int c = 0; c < 80; c++) begin
            if (out_valid_a[k] && lat < 0) begin
                lat = c;
                res = out_data_a[k];
            end
            if (in_ready_a[k]) begin
                valid_after = out_valid_a[k];
                break;
            end
            low++;
            @(posedge clk);
            #1;
        end
        out_ready_a[k] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int k, input string tag);
        check_bit($sformatf("%s_in_ready_k%0d", tag, k), in_ready_a[k], 1'b1);
        check_bit($sformatf("%s_out_valid_k%0d", tag, k), out_valid_a[k], 1'b0);
        check_bit($sformatf("%s_busy_k%0d", tag, k), busy_a[k], 1'b0);
        check_vec($sformatf("%s_out_data_k%0d", tag, k), out_data_a[k], '0);
    endtask

    task automatic backpressure(input int k);
        logic [127:0] d;
        logic [127:0] want;
        d = rand128();
        want = subbytes_ref(d);
        @(negedge clk);
        in_valid_a[k]  = 1'b1;
        in_data_a[k]   = d;
        out_ready_a[k] = 1'b0;
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid_a[k]) break;
            @(posedge clk);
            #1;
        end
        check_bit($sformatf("bp_valid_k%0d", k), out_valid_a[k], 1'b1);
        check_vec($sformatf("bp_data_k%0d", k), out_data_a[k], want);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid_a[k] = (i % 2 == 0);
            in_data_a[k]  = rand128();
            @(posedge clk);
            #1;
            check_bit($sformatf("bp_hold_valid_k%0d", k), out_valid_a[k], 1'b1);
            check_vec($sformatf("bp_hold_data_k%0d", k), out_data_a[k], want);
            check_bit($sformatf("bp_hold_ready_k%0d", k), in_ready_a[k], 1'b0);
        end
        @(negedge clk);
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_bit($sformatf("bp_after_valid_k%0d", k), out_valid_a[k], 1'b0);
            check_bit($sformatf("bp_after_ready_k%0d", k), in_ready_a[k], 1'b1);
        end
        out_ready_a[k] = 1'b0;
    endtask

    task automatic run_random(input int k, input int nstates, input int budget);
        logic [127:0] q [$];
        logic [127:0] want;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < budget && got < nstates; cyc++) begin
            @(negedge clk);
            in_valid_a[k]  = (sent < nstates) && ($urandom_range(0, 3) != 0);
            in_data_a[k]   = rand128();
            out_ready_a[k] = ($urandom_range(0, 3) != 0);
            if (in_valid_a[k] && in_ready_a[k]) begin
                q.push_back(subbytes_ref(in_data_a[k]));
                sent++;
            end
            if (out_valid_a[k] && out_ready_a[k]) begin
                want = (q.size() > 0) ? q.pop_front() : 'x;
                check_vec($sformatf("rnd_data_k%0d_n%0d", k, got), out_data_a[k], want);
                got++;
            end
        end
        @(negedge clk);
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b0;
        check_int($sformatf("rnd_received_k%0d", k), got, nstates);
        check_int($sformatf("rnd_sent_k%0d", k), sent, nstates);
        check_int($sformatf("rnd_pending_k%0d", k), q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int low;
        int n;
        int p;
        logic [127:0] res;
        logic [127:0] pat;
        logic [127:0] pexp;
        logic valid_after;
        logic [127:0] d2;

        rst_n = 1'b1;
        for (int k = 0; k < NCFG; k++) begin
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = '0;
            out_ready_a[k] = 1'b0;
        end
        build_ref();
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) check_reset_outputs(k, "rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reference vector: LANES=1, PIPE=0.
        xfer(0, 128'h00112233445566778899aabbccddeeff, lat, res, low, valid_after);
        check_vec("vec_data", res, 128'h638293c31bfc33f5c4eeacea4bc12816);
        check_int("vec_latency", lat, 16);
        check_int("vec_in_ready_low", low, 17);
        check_bit("vec_single_transfer", valid_after, 1'b0);

        // Zero and alternating 53/01/ff patterns in every configuration.
        for (int i = 0; i < 16; i++) begin
            case (i % 3)
                0:       begin pat[8*i +: 8] = 8'h53; pexp[8*i +: 8] = 8'hed; end
                1:       begin pat[8*i +: 8] = 8'h01; pexp[8*i +: 8] = 8'h7c; end
                default: begin pat[8*i +: 8] = 8'hff; pexp[8*i +: 8] = 8'h16; end
            endcase
        end
        for (int k = 0; k < NCFG; k++) begin
            n = 16 >> (k / 2);
            p = k % 2;
            xfer(k, '0, lat, res, low, valid_after);
            check_vec($sformatf("zero_data_k%0d", k), res, {16{8'h63}});
            check_int($sformatf("zero_latency_k%0d", k), lat, n + p);
            check_int($sformatf("zero_in_ready_low_k%0d", k), low, n + p + 1);
            check_bit($sformatf("zero_single_k%0d", k), valid_after, 1'b0);
            xfer(k, pat, lat, res, low, valid_after);
            check_vec($sformatf("alt_data_k%0d", k), res, pexp);
            check_int($sformatf("alt_latency_k%0d", k), lat, n + p);
            d2 = rand128();
            xfer(k, d2, lat, res, low, valid_after);
            check_vec($sformatf("rand_data_k%0d", k), res, subbytes_ref(d2));
        end

        // Backpressure on the narrowest and widest configurations.
        backpressure(0);
        backpressure(9);

        // Reset in the middle of RUN, then a clean state afterwards.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check_bit("midrun_busy", busy_a[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        d2 = rand128();
        xfer(0, d2, lat, res, low, valid_after);
        check_vec("post_rst_data", res, subbytes_ref(d2));
        check_int("post_rst_latency", lat, 16);

        // Random back-to-back traffic.
        run_random(0, 1000, 60000);
        run_random(9, 300, 10000);
        run_random(5, 200, 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
